// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - Shared gshare predictor types, constants and saturating-counter helper
package bp_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] WEAK_NT = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    INIT   = 2'd2
  } pht_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] ghr;
    logic             taken;
  } upd_entry_t;

  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (taken && (cnt != '1)) begin
      res = cnt + CNT_W'(1);
    end else if (!taken && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_access_controller_if.sv
// rtl/pht_access_controller_if.sv - Lookup, update and PHT RAM signals of the PHT access controller
interface pht_access_controller_if #(
  parameter int IDX_W = bp_pkg::IDX_W,
  parameter int CNT_W = bp_pkg::CNT_W
);

  logic             lk_valid;
  logic [31:0]      lk_pc;
  logic [IDX_W-1:0] lk_ghr;
  logic             lk_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [IDX_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_ready;
  logic             ram_en;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [CNT_W-1:0] ram_wdata;
  logic [CNT_W-1:0] ram_rdata;
  logic             busy;

  modport master (
    output lk_valid, lk_pc, lk_ghr, upd_valid, upd_pc, upd_ghr, upd_taken, ram_rdata,
    input  lk_ready, pred_valid, pred_taken, upd_ready, ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  lk_valid, lk_pc, lk_ghr, upd_valid, upd_pc, upd_ghr, upd_taken, ram_rdata,
    output lk_ready, pred_valid, pred_taken, upd_ready, ram_en, ram_we, ram_addr, ram_wdata, busy
  );

endinterface

// File: rtl/pht_update_fifo.sv
// rtl/pht_update_fifo.sv - Synchronous DEPTH-entry FIFO for pending PHT counter updates
module pht_update_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pht_access_controller.sv
// rtl/pht_access_controller.sv - Single-port gshare PHT arbiter: lookups vs queued read-modify-write updates
// Optional macro PHT_INIT_EN: after reset, sweep WEAK_NT into every entry before serving requests.
module pht_access_controller #(
  parameter int IDX_W      = bp_pkg::IDX_W,
  parameter int CNT_W      = bp_pkg::CNT_W,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                    clk,
  input logic                    reset,
  pht_access_controller_if.slave bus
);

  import bp_pkg::*;

  localparam int              SCW        = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0]  STARVE_LIM = SCW'(STARVE_MAX);
`ifdef PHT_INIT_EN
  localparam pht_state_e      RESET_STATE = INIT;
`else
  localparam pht_state_e      RESET_STATE = IDLE;
`endif

  pht_state_e       r_state;
  pht_state_e       w_next_state;
  logic [SCW-1:0]   r_starve_cnt;
  upd_entry_t       r_work;
  upd_entry_t       w_head;
  upd_entry_t       w_push_entry;
  logic             r_pred_pending;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_take_upd;
  logic             w_grant_lk;
  logic             w_pop;
  logic             w_push;
  logic             w_upd_ready;
  logic [IDX_W-1:0] w_lk_idx;
  logic             w_ram_en;
  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_addr;
  logic [CNT_W-1:0] w_ram_wdata;
  logic             w_unused_pc;
`ifdef PHT_INIT_EN
  logic [IDX_W-1:0] r_init_addr;
`endif

  assign w_lk_idx     = bus.lk_pc[IDX_W+1:2] ^ bus.lk_ghr;
  assign w_push_entry = '{idx: bus.upd_pc[IDX_W+1:2], ghr: bus.upd_ghr, taken: bus.upd_taken};
  assign w_unused_pc  = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                          bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

  // Updates win when lookups are idle or have held the port STARVE_MAX times in a row.
  assign w_take_upd  = (r_state == IDLE) && !w_fifo_empty &&
                       (!bus.lk_valid || (r_starve_cnt == STARVE_LIM));
  assign w_grant_lk  = reset && (r_state == IDLE) && bus.lk_valid && !w_take_upd;
  assign w_pop       = reset && w_take_upd;
  assign w_upd_ready = reset && !w_fifo_full && (r_state != INIT);
  assign w_push      = bus.upd_valid && w_upd_ready;

  pht_update_fifo #(
    .DEPTH (QDEPTH),
    .DW    ($bits(upd_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_take_upd) w_next_state = UPD_RD;
      UPD_RD:  w_next_state = IDLE;
`ifdef PHT_INIT_EN
      INIT:    if (r_init_addr == '1) w_next_state = IDLE;
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_take_upd) begin
          w_ram_en   = 1'b1;
          w_ram_addr = w_head.idx ^ w_head.ghr;
        end else if (w_grant_lk) begin
          w_ram_en   = 1'b1;
          w_ram_addr = w_lk_idx;
        end
      end
      UPD_RD: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = r_work.idx ^ r_work.ghr;
        w_ram_wdata = sat_update(bus.ram_rdata, r_work.taken);
      end
`ifdef PHT_INIT_EN
      INIT: begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = r_init_addr;
        w_ram_wdata = WEAK_NT;
      end
`endif
      default: begin
        w_ram_en = 1'b0;
      end
    endcase
    // Reset wins over an in-flight write so the old counter survives.
    if (!reset) begin
      w_ram_en = 1'b0;
      w_ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_starve_cnt   <= '0;
      r_pred_pending <= 1'b0;
      r_work         <= '0;
    end else begin
      r_pred_pending <= w_grant_lk;
      if (w_pop) begin
        r_work       <= w_head;
        r_starve_cnt <= '0;
      end else if (w_grant_lk && !w_fifo_empty && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + SCW'(1);
      end
    end
  end

`ifdef PHT_INIT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_init_addr <= '0;
    end else if (r_state == INIT) begin
      r_init_addr <= r_init_addr + IDX_W'(1);
    end
  end
`endif

  assign bus.lk_ready   = w_grant_lk;
  assign bus.upd_ready  = w_upd_ready;
  assign bus.pred_valid = reset && r_pred_pending;
  assign bus.pred_taken = reset && r_pred_pending && bus.ram_rdata[CNT_W-1];
  assign bus.ram_en     = w_ram_en;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_wdata  = w_ram_wdata;
  assign bus.busy       = reset && ((r_state != IDLE) || !w_fifo_empty);

endmodule

// File: tb/tb_pht_access_controller.sv
// tb/tb_pht_access_controller.sv - Directed self-checking bench for pht_access_controller with a PHT RAM model
module tb_pht_access_controller;

  logic       clk = 1'b0;
  logic       reset;
  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] mem [16];
  logic       pre_en;
  logic [3:0] pre_addr;
  logic [1:0] pre_data;
  int         wr_cnt = 0;
  logic [3:0] wr_addr_log [256];
  logic [1:0] wr_data_log [256];
  int         base;
  int         k;
  int         push_cyc [3];

  pht_access_controller_if bus ();

  pht_access_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (bus.ram_en && bus.ram_we) begin
      mem[bus.ram_addr]          <= bus.ram_wdata;
      wr_addr_log[wr_cnt[7:0]]   <= bus.ram_addr;
      wr_data_log[wr_cnt[7:0]]   <= bus.ram_wdata;
      wr_cnt                     <= wr_cnt + 1;
    end else if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] addr, input logic [1:0] data);
    step();
    pre_en   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    step();
    pre_en   = 1'b0;
  endtask

  task automatic after_reset();
`ifdef PHT_INIT_EN
    bus.lk_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("init_we", bus.ram_we, 1);
      chk("init_addr", bus.ram_addr, i);
      chk("init_wdata", bus.ram_wdata, 1);
      chk("init_lk_ready", bus.lk_ready, 0);
      step();
    end
    bus.lk_valid = 1'b0;
`endif
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [3:0] ghr, input logic taken,
                           input logic [3:0] addr, input logic [1:0] wdata);
    step();
    bus.upd_valid = 1'b1;
    bus.upd_pc    = pc;
    bus.upd_ghr   = ghr;
    bus.upd_taken = taken;
    #1;
    chk("upd_push_ready", bus.upd_ready, 1);
    chk("upd_busy_before", bus.busy, 0);
    step();
    bus.upd_valid = 1'b0;
    #1;
    chk("upd_rd_en", bus.ram_en, 1);
    chk("upd_rd_we", bus.ram_we, 0);
    chk("upd_rd_addr", bus.ram_addr, addr);
    chk("upd_rd_busy", bus.busy, 1);
    step();
    #1;
    chk("upd_wr_we", bus.ram_we, 1);
    chk("upd_wr_addr", bus.ram_addr, addr);
    chk("upd_wr_data", bus.ram_wdata, wdata);
    step();
  endtask

  initial begin
    reset         = 1'b0;
    pre_en        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    push_cyc      = '{-1, -1, -1};
    bus.ram_rdata = '0;
    bus.lk_valid  = 1'b1;
    bus.lk_pc     = 32'h10;
    bus.lk_ghr    = '0;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h10;
    bus.upd_ghr   = '0;
    bus.upd_taken = 1'b1;
    step();
    step();
    #1;
    chk("rst_lk_ready", bus.lk_ready, 0);
    chk("rst_upd_ready", bus.upd_ready, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_pred_taken", bus.pred_taken, 0);
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    preload(4'd4, 2'b11);
    preload(4'd10, 2'b01);
    reset = 1'b1;
    after_reset();

    // back-to-back lookups: idx 4 (strong taken) then 0x24>>2 ^ 3 = 10 (weak not-taken)
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h10;
    bus.lk_ghr   = 4'h0;
    #1;
    chk("lk1_ready", bus.lk_ready, 1);
    chk("lk1_en", bus.ram_en, 1);
    chk("lk1_we", bus.ram_we, 0);
    chk("lk1_addr", bus.ram_addr, 4);
    step();
    bus.lk_pc  = 32'h24;
    bus.lk_ghr = 4'h3;
    #1;
    chk("lk1_pred_valid", bus.pred_valid, 1);
    chk("lk1_pred_taken", bus.pred_taken, 1);
    chk("lk2_ready", bus.lk_ready, 1);
    chk("lk2_addr", bus.ram_addr, 10);
    step();
    bus.lk_valid = 1'b0;
    #1;
    chk("lk2_pred_valid", bus.pred_valid, 1);
    chk("lk2_pred_taken", bus.pred_taken, 0);
    chk("lk_idle_en", bus.ram_en, 0);
    step();
    #1;
    chk("lk_pred_drop", bus.pred_valid, 0);

    do_update(32'h10, 4'h0, 1'b1, 4'd4, 2'b11);
    #1;
    chk("upd_sat_busy_drop", bus.busy, 0);
    chk("upd_sat_idle_en", bus.ram_en, 0);
    preload(4'd4, 2'b00);
    do_update(32'h10, 4'h0, 1'b0, 4'd4, 2'b00);
    preload(4'd4, 2'b01);
    do_update(32'h10, 4'h0, 1'b1, 4'd4, 2'b10);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h10;
    bus.lk_ghr   = 4'h0;
    #1;
    chk("raw_lk_ready", bus.lk_ready, 1);
    step();
    bus.lk_valid = 1'b0;
    #1;
    chk("raw_pred_taken", bus.pred_taken, 1);

    // starvation: lookup wins the empty-FIFO tie, then exactly 4 grants before the update
    preload(4'd8, 2'b01);
    step();
    bus.lk_valid  = 1'b1;
    bus.lk_pc     = 32'h10;
    bus.lk_ghr    = 4'h0;
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h20;
    bus.upd_ghr   = 4'h0;
    bus.upd_taken = 1'b1;
    #1;
    chk("st_lk_wins", bus.lk_ready, 1);
    chk("st_upd_ready", bus.upd_ready, 1);
    chk("st_lk_addr", bus.ram_addr, 4);
    for (int i = 1; i <= 4; i++) begin
      step();
      bus.upd_valid = 1'b0;
      #1;
      chk("st_grant", bus.lk_ready, 1);
    end
    step();
    #1;
    chk("st_rd_lk_ready", bus.lk_ready, 0);
    chk("st_rd_en", bus.ram_en, 1);
    chk("st_rd_we", bus.ram_we, 0);
    chk("st_rd_addr", bus.ram_addr, 8);
    step();
    #1;
    chk("st_wr_lk_ready", bus.lk_ready, 0);
    chk("st_wr_we", bus.ram_we, 1);
    chk("st_wr_data", bus.ram_wdata, 2);
    step();
    #1;
    chk("st_resume", bus.lk_ready, 1);
    step();
    bus.lk_valid = 1'b0;

    // three updates under continuous lookups with a 2-deep FIFO
    preload(4'd1, 2'b00);
    preload(4'd3, 2'b10);
    preload(4'd0, 2'b11);
    base = wr_cnt;
    k    = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      bus.lk_valid  = 1'b1;
      bus.lk_pc     = 32'h3C;
      bus.lk_ghr    = 4'h0;
      bus.upd_valid = (k < 3);
      case (k)
        0:       begin bus.upd_pc = 32'h04; bus.upd_ghr = 4'h0; bus.upd_taken = 1'b1; end
        1:       begin bus.upd_pc = 32'h08; bus.upd_ghr = 4'h1; bus.upd_taken = 1'b0; end
        default: begin bus.upd_pc = 32'h0C; bus.upd_ghr = 4'h3; bus.upd_taken = 1'b1; end
      endcase
      #1;
      if (c == 2) chk("q_full_ready", bus.upd_ready, 0);
      if (bus.upd_valid && bus.upd_ready) begin
        push_cyc[k] = c;
        k++;
      end
    end
    chk("q_push0_cyc", push_cyc[0], 0);
    chk("q_push1_cyc", push_cyc[1], 1);
    chk("q_push2_cyc", push_cyc[2], 6);
    chk("q_nwrites", wr_cnt - base, 3);
    chk("q_w0_addr", wr_addr_log[base], 1);
    chk("q_w0_data", wr_data_log[base], 1);
    chk("q_w1_addr", wr_addr_log[base + 1], 3);
    chk("q_w1_data", wr_data_log[base + 1], 1);
    chk("q_w2_addr", wr_addr_log[base + 2], 0);
    chk("q_w2_data", wr_data_log[base + 2], 3);
    step();
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;

    // reset during the write cycle must leave the counter unchanged
    preload(4'd5, 2'b01);
    base = wr_cnt;
    step();
    bus.upd_valid = 1'b1;
    bus.upd_pc    = 32'h14;
    bus.upd_ghr   = 4'h0;
    bus.upd_taken = 1'b1;
    #1;
    chk("rw_push_ready", bus.upd_ready, 1);
    step();
    bus.upd_valid = 1'b0;
    #1;
    chk("rw_rd_addr", bus.ram_addr, 5);
    step();
    reset = 1'b0;
    #1;
    chk("rw_wr_en_off", bus.ram_en, 0);
    chk("rw_wr_we_off", bus.ram_we, 0);
    step();
    reset = 1'b1;
    #1;
    chk("rw_no_write", wr_cnt - base, 0);
    after_reset();
    #1;
    chk("rw_busy", bus.busy, 0);
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h14;
    bus.lk_ghr   = 4'h0;
    #1;
    chk("rw_lk_ready", bus.lk_ready, 1);
    step();
    bus.lk_valid = 1'b0;
    #1;
    chk("rw_pred_valid", bus.pred_valid, 1);
    chk("rw_pred_taken", bus.pred_taken, 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
